// File: rtl/ram_arb_pkg.sv
// Types and helpers shared by the RAM data-port arbiter and its lane-alignment logic.
// Access sizes, FSM states, the latched request record and the request legality rule.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // A request is rejected for an illegal size, a misaligned half/word, or an address past the RAM.
  function automatic logic access_illegal(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem_bytes);
    logic bad;
    bad = (addr >= mem_bytes);
    case (size)
      MEM_B:   ;
      MEM_H:   bad = bad | addr[0];
      MEM_W:   bad = bad | (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both requester ports and the RAM data port around the arbiter.
// slave = the arbiter itself; master = the requesters plus the RAM behind it.
interface ram_port_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [1:0]  m0_size;
  logic        m0_unsigned;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic        m1_unsigned;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_wr;

  modport slave (
    input  m0_req, m0_we, m0_size, m0_unsigned, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_size, m1_unsigned, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata, m1_err,
    output ram_addr, ram_wdata, ram_wr,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_size, m0_unsigned, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata, m0_err,
    output m1_req, m1_we, m1_size, m1_unsigned, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata, m1_err,
    input  ram_addr, ram_wdata, ram_wr,
    output ram_rdata
  );

endinterface

// File: rtl/ram_lane_align.sv
// Byte/half lane handling on a word-wide RAM: load extraction with sign/zero extension,
// and the merge of store data into a previously read word for read-modify-write.
module ram_lane_align
  import ram_arb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = rdata[{off, 3'b000} +: 8];
    load_half = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (size)
      MEM_B:   load_data = {{24{load_byte[7] & ~is_unsigned}}, load_byte};
      MEM_H:   load_data = {{16{load_half[15] & ~is_unsigned}}, load_half};
      default: ;
    endcase
  end

  // Sub-word stores keep every lane of the captured word except the one being written.
  always_comb begin
    merge_data = wdata;
    case (size)
      MEM_B: begin
        merge_data = word;
        merge_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_H: begin
        merge_data = word;
        merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM data port between two requesters (m0 = CPU LSU, m1 = loader/debug),
// with sub-word loads/stores, read-modify-write for partial stores, and request rejection.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32'd4096,
  parameter bit          RR_EN     = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  req_t        req_q, req_d;
  logic        owner_q, owner_d;      // 0 = m0 owns the transaction, 1 = m1
  logic        prio_m1_q, prio_m1_d;  // 1 = m1 wins the next tie
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        gnt_m0, gnt_m1;
  req_t        sel_req;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] word_addr;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Grants are offered only from IDLE and never during reset, so a gnt is always captured.
  always_comb begin
    gnt_m0 = 1'b0;
    gnt_m1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (bus.m0_req && bus.m1_req) begin
        if (RR_EN && prio_m1_q) gnt_m1 = 1'b1;
        else                    gnt_m0 = 1'b1;
      end else begin
        gnt_m0 = bus.m0_req;
        gnt_m1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    if (gnt_m1) begin
      sel_req = '{we: bus.m1_we, size: bus.m1_size, is_unsigned: bus.m1_unsigned,
                  addr: bus.m1_addr, wdata: bus.m1_wdata};
    end else begin
      sel_req = '{we: bus.m0_we, size: bus.m0_size, is_unsigned: bus.m0_unsigned,
                  addr: bus.m0_addr, wdata: bus.m0_wdata};
    end
  end

  assign word_addr = {req_q.addr[31:2], 2'b00};

  ram_lane_align u_align (
    .rdata       (bus.ram_rdata),
    .word        (rdata_q),
    .wdata       (req_q.wdata),
    .off         (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    // NOTE: every signal gets a default here, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    req_d      = req_q;
    owner_d    = owner_q;
    prio_m1_d  = prio_m1_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wr     = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE: begin
        if (gnt_m0 || gnt_m1) begin
          req_d     = sel_req;
          owner_d   = gnt_m1;
          prio_m1_d = gnt_m0;
          rdata_d   = '0;
          err_d     = access_illegal(sel_req.size, sel_req.addr, MEM_BYTES);
          state_d   = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        ram_addr = word_addr;
        if (!req_q.we) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (req_q.size == MEM_W) begin
          ram_wr    = 1'b1;
          ram_wdata = req_q.wdata;
          state_d   = RESP;
        end else begin
          // Partial store: hold the current word so RMW can rewrite only the target lane.
          rdata_d = bus.ram_rdata;
          state_d = RMW;
        end
      end
      RMW: begin
        ram_addr  = word_addr;
        ram_wr    = 1'b1;
        ram_wdata = merge_data;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (!req_q.we && !err_q) resp_rdata = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      owner_q   <= 1'b0;
      prio_m1_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      owner_q   <= owner_d;
      prio_m1_q <= prio_m1_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.m0_gnt   = gnt_m0;
  assign bus.m1_gnt   = gnt_m1;
  assign bus.m0_done  = resp_valid & ~owner_q;
  assign bus.m1_done  = resp_valid & owner_q;
  assign bus.m0_err   = resp_valid & ~owner_q & err_q;
  assign bus.m1_err   = resp_valid & owner_q & err_q;
  assign bus.m0_rdata = owner_q ? '0 : resp_rdata;
  assign bus.m1_rdata = owner_q ? resp_rdata : '0;

  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.ram_wr    = ram_wr;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a word-array reference model of the RAM and the access rules.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   last_gnt = 1'b1;

  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  ram_port_arbiter_if bus();
  ram_port_arbiter_if bus_fp();

  ram_port_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ram_port_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp.slave)
  );

  assign bus.ram_rdata    = ram[bus.ram_addr[11:2]];
  assign bus_fp.ram_rdata = 32'h0;

  always @(posedge clk) if (bus.ram_wr) ram[bus.ram_addr[11:2]] <= bus.ram_wdata;

  task automatic set_req(input bit side, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (side) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_size = size;
      bus.m1_unsigned = uns; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_size = size;
      bus.m0_unsigned = uns; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // Issues one request and observes it; lat = cycles from gnt to done (-1 on timeout).
  task automatic drive_txn(input bit side, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int wr_cnt, output int wr_at, output bit quiet);
    bit got = 1'b0;
    bit fin = 1'b0;
    lat = -1; rd = '0; er = 1'b0; wr_cnt = 0; wr_at = -1; quiet = 1'b1;
    @(posedge clk); #1;
    set_req(side, 1'b1, we, size, uns, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = side ? bus.m1_gnt : bus.m0_gnt;
      if (side ? bus.m0_gnt : bus.m1_gnt) quiet = 1'b0;
    end
    @(posedge clk); #1;
    if (side) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
    if (!got) return;
    last_gnt = side;
    for (int n = 1; n <= 8 && !fin; n++) begin
      @(negedge clk);
      if (bus.ram_wr) begin wr_cnt++; wr_at = n; end
      if (side ? (bus.m0_gnt | bus.m0_done | bus.m0_err | (|bus.m0_rdata))
               : (bus.m1_gnt | bus.m1_done | bus.m1_err | (|bus.m1_rdata))) quiet = 1'b0;
      if (side ? bus.m1_done : bus.m0_done) begin
        fin = 1'b1;
        lat = n;
        rd  = side ? bus.m1_rdata : bus.m0_rdata;
        er  = side ? bus.m1_err : bus.m0_err;
      end
    end
  endtask

  // Reference: the RAM as a word array; accesses computed from the size/offset rules.
  task automatic model_txn(input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] exp_rd, output logic exp_err,
                           output int exp_lat, output int exp_wr);
    int unsigned idx, sh;
    logic [31:0] mask, word;
    exp_rd = '0; exp_wr = 0;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
    exp_lat = 1;
    if (exp_err) return;
    idx  = addr / 4;
    sh   = 8 * (addr % 4);
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    word = ref_mem[idx];
    if (!we) begin
      exp_rd = (word >> sh) & mask;
      if (!uns && size == 2'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && size == 2'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      exp_lat = 2;
    end else begin
      ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      exp_wr  = 1;
      exp_lat = (size == 2'd2) ? 2 : 3;
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    int lat, wc, wa; logic [31:0] rd; logic er; bit q;
    drive_txn(1'b1, 1'b1, 2'b10, 1'b0, addr, data, lat, rd, er, wc, wa, q);
    ref_mem[addr[11:2]] = data;
    checks++;
    if (lat !== 2 || er !== 1'b0 || wc !== 1)
      begin errors++; $display("FAIL preload addr=%h lat=%0d err=%b wr=%0d want lat=2 err=0 wr=1", addr, lat, er, wc); end
  endtask

  task automatic test_reset();
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    {bus_fp.m0_req, bus_fp.m0_we, bus_fp.m0_size, bus_fp.m0_unsigned} = '0;
    {bus_fp.m1_req, bus_fp.m1_we, bus_fp.m1_size, bus_fp.m1_unsigned} = '0;
    bus_fp.m0_addr = '0; bus_fp.m0_wdata = '0; bus_fp.m1_addr = '0; bus_fp.m1_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m0_done, bus.m0_err, bus.m1_gnt, bus.m1_done, bus.m1_err, bus.ram_wr} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl got %b want 0", {bus.m0_gnt, bus.m0_done, bus.m0_err, bus.m1_gnt, bus.m1_done, bus.m1_err, bus.ram_wr}); end
    checks++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.ram_addr, bus.ram_wdata} !== 128'b0)
      begin errors++; $display("FAIL reset_data got %h want 0", {bus.m0_rdata, bus.m1_rdata, bus.ram_addr, bus.ram_wdata}); end
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.m0_done, bus.m1_done, bus.ram_wr, bus.ram_addr} !== 35'b0)
      begin errors++; $display("FAIL idle_after_reset got %h want 0", {bus.m0_done, bus.m1_done, bus.ram_wr, bus.ram_addr}); end
  endtask

  task automatic test_load_extend();
    int lat, wc, wa; logic [31:0] rd; logic er; bit q;
    logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    bit          un   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad   [4] = '{32'h3, 32'h3, 32'h2, 32'h0};
    logic [31:0] want [4] = '{32'hFFFF_FF8A, 32'h0000_008A, 32'hFFFF_8A7B, 32'h0000_6C5D};
    preload(32'h0, 32'h8A7B_6C5D);
    for (int i = 0; i < 4; i++) begin
      drive_txn(1'b0, 1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, wc, wa, q);
      checks++;
      if (rd !== want[i]) begin errors++; $display("FAIL load_data[%0d] got %h want %h", i, rd, want[i]); end
      checks++;
      if (lat !== 2 || er !== 1'b0 || wc !== 0 || !q)
        begin errors++; $display("FAIL load_flags[%0d] lat=%0d err=%b wr=%0d quiet=%b want 2/0/0/1", i, lat, er, wc, q); end
    end
  endtask

  task automatic test_subword_store();
    int lat, wc, wa; logic [31:0] rd; logic er; bit q;
    preload(32'h100, 32'h1122_3344);
    drive_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, lat, rd, er, wc, wa, q);
    checks++;
    if (lat !== 3 || wc !== 1 || wa !== 2 || er !== 1'b0 || rd !== 32'h0 || !q)
      begin errors++; $display("FAIL sh_timing lat=%0d wr=%0d wr_at=%0d err=%b rd=%h want 3/1/2/0/0", lat, wc, wa, er, rd); end
    checks++;
    if (ram[32'h40] !== 32'hBEEF_3344) begin errors++; $display("FAIL sh_word got %h want BEEF3344", ram[32'h40]); end
    drive_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF55, lat, rd, er, wc, wa, q);
    checks++;
    if (lat !== 3 || wc !== 1 || ram[32'h40] !== 32'hBEEF_5544)
      begin errors++; $display("FAIL sb_word lat=%0d wr=%0d word=%h want 3/1/BEEF5544", lat, wc, ram[32'h40]); end
  endtask

  task automatic test_round_robin();
    int  n_gnt = 0;
    bit  exp_m1 = ~last_gnt;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 60 && n_gnt < 10; i++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) begin
        checks++;
        if ((bus.m0_gnt && bus.m1_gnt) || bus.m1_gnt !== exp_m1)
          begin errors++; $display("FAIL rr_order grant %0d got m0=%b m1=%b want m1=%b", n_gnt, bus.m0_gnt, bus.m1_gnt, exp_m1); end
        last_gnt = bus.m1_gnt;
        exp_m1   = ~exp_m1;
        n_gnt++;
      end
    end
    @(posedge clk); #1;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (n_gnt != 10) begin errors++; $display("FAIL rr_count got %0d want 10", n_gnt); end
  endtask

  task automatic test_fixed_priority();
    int  n_m0 = 0;
    int  n_m1 = 0;
    bit  seen = 1'b0;
    @(posedge clk); #1;
    bus_fp.m0_we = 1'b0; bus_fp.m0_size = 2'b10; bus_fp.m0_addr = 32'h10;
    bus_fp.m1_we = 1'b0; bus_fp.m1_size = 2'b10; bus_fp.m1_addr = 32'h20;
    bus_fp.m0_req = 1'b1; bus_fp.m1_req = 1'b1;
    for (int i = 0; i < 60 && n_m0 < 6; i++) begin
      @(negedge clk);
      if (bus_fp.m0_gnt) n_m0++;
      if (bus_fp.m1_gnt) n_m1++;
    end
    @(posedge clk); #1;
    bus_fp.m0_req = 1'b0;
    checks++;
    if (n_m0 != 6 || n_m1 != 0) begin errors++; $display("FAIL fp_starve m0=%0d m1=%0d want 6/0", n_m0, n_m1); end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus_fp.m1_gnt;
    end
    @(posedge clk); #1;
    bus_fp.m1_req = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (!seen) begin errors++; $display("FAIL fp_m1_served got no gnt want gnt"); end
  endtask

  task automatic test_errors();
    int lat, wc, wa; logic [31:0] rd; logic er; bit q;
    bit          we [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [31:0] ad [6] = '{32'h006, 32'h001, 32'h000, 32'h1000, 32'h002, 32'h1000};
    for (int i = 0; i < 6; i++) begin
      drive_txn(i[0], we[i], sz[i], 1'b0, ad[i], 32'hDEAD_BEEF, lat, rd, er, wc, wa, q);
      checks++;
      if (lat !== 1 || er !== 1'b1 || wc !== 0 || rd !== 32'h0 || !q)
        begin errors++; $display("FAIL err_case[%0d] lat=%0d err=%b wr=%0d rd=%h quiet=%b want 1/1/0/0/1", i, lat, er, wc, rd, q); end
    end
    checks++;
    if (ram[0] !== 32'h8A7B_6C5D || ram[32'h40] !== 32'hBEEF_5544)
      begin errors++; $display("FAIL err_ram_intact got %h %h want 8A7B6C5D BEEF5544", ram[0], ram[32'h40]); end
  endtask

  task automatic test_reset_mid_rmw();
    int lat, wc, wa; logic [31:0] rd; logic er; bit q;
    bit got = 1'b0;
    bit stray = 1'b0;
    preload(32'h200, 32'hA5A5_1234);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_0055);
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.m0_gnt; end
    @(posedge clk); #1;
    bus.m0_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!got || bus.ram_wr !== 1'b1 || bus.ram_addr !== 32'h200)
      begin errors++; $display("FAIL rmw_reached gnt=%b wr=%b addr=%h want 1/1/200", got, bus.ram_wr, bus.ram_addr); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_wr !== 1'b0 || bus.ram_addr !== 32'h0 || bus.m0_done !== 1'b0)
      begin errors++; $display("FAIL async_drop wr=%b addr=%h done=%b want 0/0/0", bus.ram_wr, bus.ram_addr, bus.m0_done); end
    repeat (3) begin @(negedge clk); if (bus.m0_done || bus.ram_wr) stray = 1'b1; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_gnt = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.m0_done || bus.m1_done || bus.ram_wr) stray = 1'b1; end
    checks++;
    if (stray) begin errors++; $display("FAIL lost_txn got done/wr after reset want none"); end
    checks++;
    if (ram[32'h80] !== 32'hA5A5_1234) begin errors++; $display("FAIL rmw_intact got %h want A5A51234", ram[32'h80]); end
    drive_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, wc, wa, q);
    checks++;
    if (lat !== 2 || rd !== 32'hA5A5_1234 || er !== 1'b0)
      begin errors++; $display("FAIL post_reset_load lat=%0d rd=%h err=%b want 2/A5A51234/0", lat, rd, er); end
    drive_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_0055, lat, rd, er, wc, wa, q);
    checks++;
    if (lat !== 3 || ram[32'h80] !== 32'hA5A5_1255)
      begin errors++; $display("FAIL post_reset_sb lat=%0d word=%h want 3/A5A51255", lat, ram[32'h80]); end
  endtask

  task automatic test_random();
    int lat, wc, wa, elat, ewr; logic [31:0] rd, erd, addr, wd; logic er, eerr; bit q;
    bit side, we, uns; logic [1:0] sz;
    for (int i = 0; i < 16; i++) preload(32'h300 + 32'(4 * i), $urandom);
    for (int i = 0; i < 80; i++) begin
      side = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'h300 + $urandom_range(0, 63);
      wd   = $urandom;
      model_txn(we, sz, uns, addr, wd, erd, eerr, elat, ewr);
      drive_txn(side, we, sz, uns, addr, wd, lat, rd, er, wc, wa, q);
      checks++;
      if (lat !== elat) begin errors++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, elat); end
      checks++;
      if (er !== eerr || rd !== erd)
        begin errors++; $display("FAIL rand_resp[%0d] got err=%b rd=%h want err=%b rd=%h", i, er, rd, eerr, erd); end
      checks++;
      if (wc !== ewr || !q) begin errors++; $display("FAIL rand_wr[%0d] got wr=%0d quiet=%b want wr=%0d quiet=1", i, wc, q, ewr); end
    end
    for (int i = 32'hC0; i < 32'hD0; i++) begin
      checks++;
      if (ram[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem[%0h] got %h want %h", i * 4, ram[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_extend();
    test_subword_store();
    test_round_robin();
    test_fixed_priority();
    test_errors();
    test_reset_mid_rmw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
